// File: rtl/rvh_tlb_miss_router_if.sv
// rvh_tlb_miss_router_if: TLB miss request/refill and PTW walk bundle.
// The slave modport is the router; the master modport is the TLBs and PTW around it.
interface rvh_tlb_miss_router_if #(
    parameter int VPN_WIDTH = 27,
    parameter int PTE_WIDTH = 64,
    parameter int LVL_WIDTH = 2
);
    logic                 dtlb_miss_req_vld;
    logic [VPN_WIDTH-1:0] dtlb_miss_req_vpn;
    logic                 dtlb_miss_req_rdy;
    logic                 itlb_miss_req_vld;
    logic [VPN_WIDTH-1:0] itlb_miss_req_vpn;
    logic                 itlb_miss_req_rdy;
    logic                 dtlb_flush;
    logic                 itlb_flush;
    logic                 ptw_req_vld;
    logic [VPN_WIDTH-1:0] ptw_req_vpn;
    logic                 ptw_req_rdy;
    logic                 ptw_resp_vld;
    logic [PTE_WIDTH-1:0] ptw_resp_pte;
    logic [LVL_WIDTH-1:0] ptw_resp_lvl;
    logic                 ptw_resp_excp;
    logic                 dtlb_miss_resp_vld;
    logic                 itlb_miss_resp_vld;
    logic [PTE_WIDTH-1:0] miss_resp_pte;
    logic [LVL_WIDTH-1:0] miss_resp_lvl;
    logic                 miss_resp_excp;

    modport slave (
        input  dtlb_miss_req_vld, dtlb_miss_req_vpn, itlb_miss_req_vld, itlb_miss_req_vpn,
        input  dtlb_flush, itlb_flush, ptw_req_rdy,
        input  ptw_resp_vld, ptw_resp_pte, ptw_resp_lvl, ptw_resp_excp,
        output dtlb_miss_req_rdy, itlb_miss_req_rdy, ptw_req_vld, ptw_req_vpn,
        output dtlb_miss_resp_vld, itlb_miss_resp_vld, miss_resp_pte, miss_resp_lvl, miss_resp_excp
    );

    modport master (
        output dtlb_miss_req_vld, dtlb_miss_req_vpn, itlb_miss_req_vld, itlb_miss_req_vpn,
        output dtlb_flush, itlb_flush, ptw_req_rdy,
        output ptw_resp_vld, ptw_resp_pte, ptw_resp_lvl, ptw_resp_excp,
        input  dtlb_miss_req_rdy, itlb_miss_req_rdy, ptw_req_vld, ptw_req_vpn,
        input  dtlb_miss_resp_vld, itlb_miss_resp_vld, miss_resp_pte, miss_resp_lvl, miss_resp_excp
    );
endinterface

// File: rtl/rvh_tlb_miss_router.sv
// rvh_tlb_miss_router: arbitrates DTLB/ITLB misses onto one PTW and routes the refill
// back to the owning TLB, dropping it if that TLB was flushed during the walk.
module rvh_tlb_miss_router #(
    parameter bit DTLB_PRIOR = 1'b1,
    parameter int VPN_WIDTH  = 27,
    parameter int PTE_WIDTH  = 64,
    parameter int LVL_WIDTH  = 2
) (
    input logic                  clk,
    input logic                  rstn,
    rvh_tlb_miss_router_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 src_q, kill_q, d_pulse_q, i_pulse_q, excp_q;
    logic [VPN_WIDTH-1:0] vpn_q;
    logic [PTE_WIDTH-1:0] pte_q;
    logic [LVL_WIDTH-1:0] lvl_q;
    logic                 d_el, i_el, d_rdy, i_rdy, grant, own_flush, resp_take, deliver;

    assign d_el      = bus.dtlb_miss_req_vld & ~bus.dtlb_flush;
    assign i_el      = bus.itlb_miss_req_vld & ~bus.itlb_flush;
    assign grant     = d_rdy | i_rdy;
    assign own_flush = src_q ? bus.itlb_flush : bus.dtlb_flush;
    assign resp_take = (state_q == WAIT) & bus.ptw_resp_vld;
    // a flush landing on the response cycle must also cancel delivery
    assign deliver   = resp_take & ~kill_q & ~own_flush;

    always_comb begin
        state_d = state_q;
        d_rdy   = 1'b0;
        i_rdy   = 1'b0;
        unique case (state_q)
            IDLE: begin
                d_rdy   = d_el & (DTLB_PRIOR | ~i_el);
                i_rdy   = i_el & (~DTLB_PRIOR | ~d_el);
                state_d = (d_rdy | i_rdy) ? REQ : IDLE;
            end
            REQ:     state_d = bus.ptw_req_rdy ? WAIT : REQ;
            WAIT:    state_d = bus.ptw_resp_vld ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_q     <= 1'b0;
            vpn_q     <= '0;
            kill_q    <= 1'b0;
            pte_q     <= '0;
            lvl_q     <= '0;
            excp_q    <= 1'b0;
            d_pulse_q <= 1'b0;
            i_pulse_q <= 1'b0;
        end else begin
            if (grant) begin
                src_q  <= i_rdy;
                vpn_q  <= i_rdy ? bus.itlb_miss_req_vpn : bus.dtlb_miss_req_vpn;
                kill_q <= 1'b0;
            end else if (state_q != IDLE && own_flush) begin
                kill_q <= 1'b1;
            end
            if (resp_take) begin
                pte_q  <= bus.ptw_resp_pte;
                lvl_q  <= bus.ptw_resp_lvl;
                excp_q <= bus.ptw_resp_excp;
            end
            d_pulse_q <= deliver & ~src_q;
            i_pulse_q <= deliver & src_q;
        end
    end

    assign bus.dtlb_miss_req_rdy  = d_rdy;
    assign bus.itlb_miss_req_rdy  = i_rdy;
    assign bus.ptw_req_vld        = (state_q == REQ);
    assign bus.ptw_req_vpn        = vpn_q;
    assign bus.dtlb_miss_resp_vld = d_pulse_q;
    assign bus.itlb_miss_resp_vld = i_pulse_q;
    assign bus.miss_resp_pte      = pte_q;
    assign bus.miss_resp_lvl      = lvl_q;
    assign bus.miss_resp_excp     = excp_q;
endmodule

// File: tb/tb_rvh_tlb_miss_router.sv
// tb_rvh_tlb_miss_router: vector table of walks with a refill scoreboard, plus
// hand sequences for arbitration, priority, stray responses and mid-walk reset.
module tb_rvh_tlb_miss_router;
    localparam int VW = 27;
    localparam int PW = 64;
    localparam int LW = 2;

    typedef struct {
        logic          src;
        logic [VW-1:0] vpn;
        int            stall;
        logic [PW-1:0] pte;
        logic [LW-1:0] lvl;
        logic          excp;
        int            fl;
    } vec_t;

    typedef struct {
        logic          d;
        logic          i;
        logic [PW-1:0] pte;
        logic [LW-1:0] lvl;
        logic          excp;
    } resp_t;

    logic  clk = 1'b0;
    logic  rstn = 1'b1;
    int    checks = 0;
    int    errors = 0;
    resp_t sbq[$];
    vec_t  v[7];
    resp_t e;

    always #5 clk = ~clk;

    rvh_tlb_miss_router_if #(.VPN_WIDTH(VW), .PTE_WIDTH(PW), .LVL_WIDTH(LW)) a ();
    rvh_tlb_miss_router_if #(.VPN_WIDTH(VW), .PTE_WIDTH(PW), .LVL_WIDTH(LW)) b ();

    rvh_tlb_miss_router #(.DTLB_PRIOR(1'b1), .VPN_WIDTH(VW), .PTE_WIDTH(PW), .LVL_WIDTH(LW))
        u_dprio (.clk(clk), .rstn(rstn), .bus(a));
    rvh_tlb_miss_router #(.DTLB_PRIOR(1'b0), .VPN_WIDTH(VW), .PTE_WIDTH(PW), .LVL_WIDTH(LW))
        u_iprio (.clk(clk), .rstn(rstn), .bus(b));

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a.dtlb_miss_req_vld = 0; a.dtlb_miss_req_vpn = '0;
        a.itlb_miss_req_vld = 0; a.itlb_miss_req_vpn = '0;
        a.dtlb_flush = 0; a.itlb_flush = 0; a.ptw_req_rdy = 0;
        a.ptw_resp_vld = 0; a.ptw_resp_pte = '0; a.ptw_resp_lvl = '0; a.ptw_resp_excp = 0;
        b.dtlb_miss_req_vld = 0; b.dtlb_miss_req_vpn = '0;
        b.itlb_miss_req_vld = 0; b.itlb_miss_req_vpn = '0;
        b.dtlb_flush = 0; b.itlb_flush = 0; b.ptw_req_rdy = 0;
        b.ptw_resp_vld = 0; b.ptw_resp_pte = '0; b.ptw_resp_lvl = '0; b.ptw_resp_excp = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_d_rdy"}, 64'(a.dtlb_miss_req_rdy), 0);
        chk({tag, "_i_rdy"}, 64'(a.itlb_miss_req_rdy), 0);
        chk({tag, "_ptw_vld"}, 64'(a.ptw_req_vld), 0);
        chk({tag, "_ptw_vpn"}, 64'(a.ptw_req_vpn), 0);
        chk({tag, "_d_pulse"}, 64'(a.dtlb_miss_resp_vld), 0);
        chk({tag, "_i_pulse"}, 64'(a.itlb_miss_resp_vld), 0);
        chk({tag, "_pte"}, a.miss_resp_pte, 0);
        chk({tag, "_lvl"}, 64'(a.miss_resp_lvl), 0);
        chk({tag, "_excp"}, 64'(a.miss_resp_excp), 0);
    endtask

    task automatic set_req(input logic src, input logic vld, input logic [VW-1:0] vpn);
        if (src) begin a.itlb_miss_req_vld = vld; a.itlb_miss_req_vpn = vpn; end
        else     begin a.dtlb_miss_req_vld = vld; a.dtlb_miss_req_vpn = vpn; end
    endtask

    task automatic set_flush(input logic src, input logic val);
        if (src) a.itlb_flush = val;
        else     a.dtlb_flush = val;
    endtask

    task automatic send_resp(input logic [PW-1:0] pte, input logic [LW-1:0] lvl, input logic excp,
                             input logic exp_d, input logic exp_i);
        a.ptw_resp_vld = 1; a.ptw_resp_pte = pte; a.ptw_resp_lvl = lvl; a.ptw_resp_excp = excp;
        sbq.push_back('{d: exp_d, i: exp_i, pte: pte, lvl: lvl, excp: excp});
    endtask

    task automatic check_refill(input string tag);
        resp_t r;
        chk({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            r = sbq.pop_front();
            chk({tag, "_d_pulse"}, 64'(a.dtlb_miss_resp_vld), 64'(r.d));
            chk({tag, "_i_pulse"}, 64'(a.itlb_miss_resp_vld), 64'(r.i));
            chk({tag, "_pte"}, a.miss_resp_pte, r.pte);
            chk({tag, "_lvl"}, 64'(a.miss_resp_lvl), 64'(r.lvl));
            chk({tag, "_excp"}, 64'(a.miss_resp_excp), 64'(r.excp));
        end
    endtask

    // fl: 0 none, 1 owner flush in WAIT, 2 owner flush with response, 3 non-owner flush in WAIT, 4 owner flush in REQ
    task automatic walk(input vec_t w);
        logic ok;
        ok = (w.fl == 0) || (w.fl == 3);
        set_req(w.src, 1, w.vpn);
        #1;
        chk("grant_rdy", 64'(w.src ? a.itlb_miss_req_rdy : a.dtlb_miss_req_rdy), 1);
        chk("other_rdy", 64'(w.src ? a.dtlb_miss_req_rdy : a.itlb_miss_req_rdy), 0);
        tick();
        set_req(w.src, 0, '0);
        for (int k = 0; k < w.stall; k++) begin
            if (w.fl == 4 && k == 0) set_flush(w.src, 1);
            #1;
            chk("stall_vld", 64'(a.ptw_req_vld), 1);
            chk("stall_vpn", 64'(a.ptw_req_vpn), 64'(w.vpn));
            tick();
            set_flush(w.src, 0);
        end
        a.ptw_req_rdy = 1;
        #1;
        chk("req_vld", 64'(a.ptw_req_vld), 1);
        chk("req_vpn", 64'(a.ptw_req_vpn), 64'(w.vpn));
        tick();
        a.ptw_req_rdy = 0;
        chk("wait_vld", 64'(a.ptw_req_vld), 0);
        if (w.fl == 1 || w.fl == 3) begin
            set_flush(w.fl == 1 ? w.src : ~w.src, 1);
            tick();
            a.dtlb_flush = 0; a.itlb_flush = 0;
        end
        send_resp(w.pte, w.lvl, w.excp, ok & ~w.src, ok & w.src);
        if (w.fl == 2) set_flush(w.src, 1);
        tick();
        a.ptw_resp_vld = 0; a.dtlb_flush = 0; a.itlb_flush = 0;
        check_refill("walk");
    endtask

    initial begin
        clear_inputs();
        #1 rstn = 0;
        #2 chk_reset("reset");
        tick();
        tick();
        rstn = 1;
        tick();

        v[0] = '{src: 0, vpn: 27'h0000123, stall: 0, pte: 64'h1111, lvl: 2'd0, excp: 0, fl: 0};
        v[1] = '{src: 1, vpn: 27'h7FFFFFF, stall: 5, pte: 64'hFFFF_FFFF_FFFF_FFFF, lvl: 2'd3, excp: 0, fl: 0};
        v[2] = '{src: 1, vpn: 27'h002AAAA, stall: 0, pte: 64'h2222, lvl: 2'd1, excp: 0, fl: 1};
        v[3] = '{src: 0, vpn: 27'h0003333, stall: 1, pte: 64'h3333, lvl: 2'd2, excp: 0, fl: 2};
        v[4] = '{src: 1, vpn: 27'h0004444, stall: 0, pte: 64'h4444, lvl: 2'd1, excp: 1, fl: 3};
        v[5] = '{src: 0, vpn: 27'h0005555, stall: 2, pte: 64'h5555, lvl: 2'd0, excp: 0, fl: 4};
        v[6] = '{src: 0, vpn: 27'h0000000, stall: 0, pte: 64'h0, lvl: 2'd0, excp: 0, fl: 3};
        for (int n = 0; n < 7; n++) walk(v[n]);

        // simultaneous misses, DTLB priority, ITLB granted on the turnaround cycle
        a.dtlb_miss_req_vld = 1; a.dtlb_miss_req_vpn = 27'h1234;
        a.itlb_miss_req_vld = 1; a.itlb_miss_req_vpn = 27'h5678;
        #1;
        chk("sim_d_rdy", 64'(a.dtlb_miss_req_rdy), 1);
        chk("sim_i_rdy", 64'(a.itlb_miss_req_rdy), 0);
        tick();
        a.dtlb_miss_req_vld = 0;
        chk("sim_req_vpn", 64'(a.ptw_req_vpn), 64'h1234);
        chk("sim_req_i_rdy", 64'(a.itlb_miss_req_rdy), 0);
        a.ptw_req_rdy = 1;
        tick();
        a.ptw_req_rdy = 0;
        send_resp(64'hABCD, 2'd2, 0, 1, 0);
        tick();
        a.ptw_resp_vld = 0;
        check_refill("sim_d");
        chk("turn_i_rdy", 64'(a.itlb_miss_req_rdy), 1);
        tick();
        a.itlb_miss_req_vld = 0;
        chk("sim_i_vpn", 64'(a.ptw_req_vpn), 64'h5678);
        chk("sim_pulse_gone", 64'(a.dtlb_miss_resp_vld), 0);
        a.ptw_req_rdy = 1;
        tick();
        a.ptw_req_rdy = 0;
        send_resp(64'h9876, 2'd1, 0, 0, 1);
        tick();
        a.ptw_resp_vld = 0;
        check_refill("sim_i");

        // ITLB priority instance
        b.dtlb_miss_req_vld = 1; b.dtlb_miss_req_vpn = 27'h1234;
        b.itlb_miss_req_vld = 1; b.itlb_miss_req_vpn = 27'h5678;
        #1;
        chk("iprio_d_rdy", 64'(b.dtlb_miss_req_rdy), 0);
        chk("iprio_i_rdy", 64'(b.itlb_miss_req_rdy), 1);
        tick();
        b.dtlb_miss_req_vld = 0; b.itlb_miss_req_vld = 0;
        chk("iprio_vld", 64'(b.ptw_req_vld), 1);
        chk("iprio_vpn", 64'(b.ptw_req_vpn), 64'h5678);

        // a flushed requester is never granted; the other side wins instead
        a.dtlb_miss_req_vld = 1; a.dtlb_flush = 1; a.itlb_miss_req_vld = 1;
        #1;
        chk("flushreq_d_rdy", 64'(a.dtlb_miss_req_rdy), 0);
        chk("flushreq_i_rdy", 64'(a.itlb_miss_req_rdy), 1);
        a.itlb_miss_req_vld = 0;
        #1;
        chk("flushreq_only_d", 64'(a.dtlb_miss_req_rdy), 0);
        a.dtlb_miss_req_vld = 0; a.dtlb_flush = 0;

        // stray response in IDLE is ignored and data registers hold
        a.ptw_resp_vld = 1; a.ptw_resp_pte = 64'hBAD; a.ptw_resp_excp = 1;
        tick();
        a.ptw_resp_vld = 0;
        chk("stray_d", 64'(a.dtlb_miss_resp_vld), 0);
        chk("stray_i", 64'(a.itlb_miss_resp_vld), 0);
        chk("stray_pte", a.miss_resp_pte, 64'h9876);
        chk("stray_vld", 64'(a.ptw_req_vld), 0);

        // reset during WAIT
        a.dtlb_miss_req_vld = 1; a.dtlb_miss_req_vpn = 27'h77;
        tick();
        a.dtlb_miss_req_vld = 0; a.ptw_req_rdy = 1;
        tick();
        a.ptw_req_rdy = 0;
        #2 rstn = 0;
        #1 chk_reset("midrst");
        tick();
        rstn = 1;
        a.ptw_resp_vld = 1; a.ptw_resp_pte = 64'hCAFE;
        tick();
        a.ptw_resp_vld = 0;
        chk("postrst_stray_d", 64'(a.dtlb_miss_resp_vld), 0);
        chk("postrst_stray_pte", a.miss_resp_pte, 0);
        walk('{src: 0, vpn: 27'h0000ABC, stall: 1, pte: 64'h600D, lvl: 2'd2, excp: 1, fl: 0});

        chk("sb_drained", 64'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
